tag_mem_ctrl: RTL and testbench



---
 rtl/tag_mem_ctrl_if.sv | 26 ++
 rtl/tag_mem_ctrl.sv | 97 +++++++++
 tb/tb_tag_mem_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/tag_mem_ctrl_if.sv
// Requester-side request/grant/rvalid bus of the tag memory controller.
// Signal names match the controller's original port names.
interface tag_mem_ctrl_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int BYTES      = 4
);
   logic                  req_i;
   logic                  gnt_o;
   logic [ADDR_WIDTH-1:0] addr_i;
   logic                  we_i;
   logic [BYTES-1:0]      be_i;
   logic                  wtag_i;
   logic                  rvalid_o;
   logic [BYTES-1:0]      rtag_o;
   logic                  rtag_any_o;

   modport master (
      output req_i, addr_i, we_i, be_i, wtag_i,
      input  gnt_o, rvalid_o, rtag_o, rtag_any_o
   );

   modport slave (
      input  req_i, addr_i, we_i, be_i, wtag_i,
      output gnt_o, rvalid_o, rtag_o, rtag_any_o
   );
endinterface

// File: rtl/tag_mem_ctrl.sv
// Front-end for the per-byte tag RAM: sweeps it to zero after reset or on clear,
// then maps request/grant/rvalid accesses onto single-cycle RAM operations.
module tag_mem_ctrl #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WORDS  = 4096
) (
   input  logic                       clk,
   input  logic                       rst_n,
   tag_mem_ctrl_if.slave              bus,
   input  logic                       clear_i,
   output logic                       busy_o,
   output logic                       ram_en_o,
   output logic [ADDR_WIDTH-1:0]      ram_addr_o,
   output logic                       ram_we_o,
   output logic                       ram_wdata_o,
   output logic [DATA_WIDTH/8-1:0]    ram_be_o,
   input  logic [DATA_WIDTH/8-1:0]    ram_rdata_i
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int W     = NUM_WORDS / BYTES;
   localparam int CW    = (W > 1) ? $clog2(W) : 1;
   localparam int BO    = $clog2(BYTES);

   typedef enum logic {INIT, RUN} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             rvalid_q, rvalid_d;
   logic [BYTES-1:0] be_q, be_d;
   logic             gnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= INIT;
         cnt_q    <= '0;
         rvalid_q <= 1'b0;
         be_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rvalid_q <= rvalid_d;
         be_q     <= be_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rvalid_d    = 1'b0;
      be_d        = be_q;
      gnt         = 1'b0;
      busy_o      = 1'b0;
      ram_en_o    = 1'b0;
      ram_we_o    = 1'b0;
      ram_wdata_o = 1'b0;
      ram_be_o    = '0;
      ram_addr_o  = '0;
      unique case (state_q)
         INIT: begin
            busy_o     = 1'b1;
            ram_en_o   = 1'b1;
            ram_we_o   = 1'b1;
            ram_be_o   = '1;
            ram_addr_o = ADDR_WIDTH'(cnt_q) << BO;
            if (cnt_q == CW'(W - 1)) begin
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RUN: begin
            // clear wins over a simultaneous request; the requester retries after the sweep
            if (clear_i) begin
               state_d = INIT;
               cnt_d   = '0;
            end else if (bus.req_i) begin
               gnt         = 1'b1;
               rvalid_d    = 1'b1;
               be_d        = bus.be_i;
               ram_en_o    = 1'b1;
               ram_we_o    = bus.we_i;
               ram_wdata_o = bus.wtag_i;
               ram_be_o    = bus.be_i;
               ram_addr_o  = bus.addr_i;
            end
         end
         default: state_d = INIT;
      endcase
   end

   assign bus.gnt_o      = gnt;
   assign bus.rvalid_o   = rvalid_q;
   assign bus.rtag_o     = rvalid_q ? ram_rdata_i : '0;
   assign bus.rtag_any_o = rvalid_q & (|(ram_rdata_i & be_q));
endmodule

// File: tb/tb_tag_mem_ctrl.sv
// Bench for tag_mem_ctrl: behavioural tag RAM, per-word tag reference model,
// directed vector table, multi-cycle corner sequences and randomized traffic.
module tb_tag_mem_ctrl;
   localparam int AW = 12;
   localparam int NB = 4;
   localparam int W  = 1024;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           clear_i;
   logic           busy_o;
   logic           ram_en_o;
   logic [AW-1:0]  ram_addr_o;
   logic           ram_we_o;
   logic           ram_wdata_o;
   logic [NB-1:0]  ram_be_o;
   logic [NB-1:0]  ram_rdata;

   tag_mem_ctrl_if #(.ADDR_WIDTH(AW), .BYTES(NB)) bus ();

   tag_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_WORDS(4096)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .clear_i     (clear_i),
      .busy_o      (busy_o),
      .ram_en_o    (ram_en_o),
      .ram_addr_o  (ram_addr_o),
      .ram_we_o    (ram_we_o),
      .ram_wdata_o (ram_wdata_o),
      .ram_be_o    (ram_be_o),
      .ram_rdata_i (ram_rdata)
   );

   always #5 clk = ~clk;

   // Tag RAM stand-in: registered read, old data on read-during-write, no reset.
   logic [NB-1:0] mem [W] = '{default: 4'hF};
   always @(posedge clk) begin
      if (ram_en_o) begin
         ram_rdata <= mem[ram_addr_o[AW-1:2]];
         if (ram_we_o)
            for (int b = 0; b < NB; b++)
               if (ram_be_o[b]) mem[ram_addr_o[AW-1:2]][b] <= ram_wdata_o;
      end
   end

   // Reference model: tag bits per word plus remaining sweep cycles.
   logic [NB-1:0] refw [W];
   int            sweep_left;
   logic          exp_rv;
   logic [NB-1:0] exp_rtag;
   logic          exp_any;
   logic [NB-1:0] last_rtag;
   logic          last_any;
   logic          last_rv;
   int            n_checks = 0;
   int            n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic check_reset();
      chk("reset_values",
          32'({bus.gnt_o, bus.rvalid_o, bus.rtag_o, bus.rtag_any_o, busy_o,
               ram_en_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o}),
          32'({1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 4'hF, 1'b0}));
   endtask

   // One clock cycle: drive at the falling edge, sample 1 ns later, advance the model.
   task automatic tick(input logic req, input logic we, input logic [AW-1:0] addr,
                       input logic [NB-1:0] be, input logic wtag, input logic clr);
      logic          grant;
      logic [NB-1:0] old;
      bus.req_i  = req;
      bus.we_i   = we;
      bus.addr_i = addr;
      bus.be_i   = be;
      bus.wtag_i = wtag;
      clear_i    = clr;
      #1;
      last_rv   = bus.rvalid_o;
      last_rtag = bus.rtag_o;
      last_any  = bus.rtag_any_o;
      chk("rvalid", 32'(bus.rvalid_o), 32'(exp_rv));
      chk("rtag", 32'(bus.rtag_o), 32'(exp_rv ? exp_rtag : 4'h0));
      chk("rtag_any", 32'(bus.rtag_any_o), 32'(exp_rv & exp_any));
      grant = 1'b0;
      if (sweep_left > 0) begin
         chk("sweep_busy_gnt", 32'({busy_o, bus.gnt_o}), 32'(2'b10));
         chk("sweep_addr", 32'(ram_addr_o), 32'((W - sweep_left) * 4));
         chk("sweep_ctl", 32'({ram_en_o, ram_we_o, ram_wdata_o, ram_be_o}), 32'({3'b110, 4'hF}));
         sweep_left--;
      end else begin
         grant = req & ~clr;
         chk("run_busy", 32'(busy_o), 32'(0));
         chk("gnt", 32'(bus.gnt_o), 32'(grant));
         if (grant)
            chk("ram_access", 32'({ram_en_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o}),
                32'({1'b1, we, addr, be, wtag}));
         else
            chk("ram_idle", 32'({ram_en_o, ram_we_o}), 32'(2'b00));
         if (clr) begin
            sweep_left = W;
            foreach (refw[i]) refw[i] = '0;
         end
      end
      if (grant) begin
         old      = refw[addr[AW-1:2]];
         exp_rtag = old;
         exp_any  = |(old & be);
         if (we)
            for (int b = 0; b < NB; b++)
               if (be[b]) refw[addr[AW-1:2]][b] = wtag;
      end
      exp_rv = grant;
      @(negedge clk);
   endtask

   task automatic idle();
      tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic async_reset_pulse();
      #7 rst_n = 1'b0;
      #1 check_reset();
      sweep_left = W;
      exp_rv     = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [NB-1:0] be;
      logic          wtag;
      logic [NB-1:0] exp_rtag;
      logic          exp_any;
   } vec_t;

   vec_t tbl [8];
   int   npulse;

   initial begin
      tbl[0] = '{1'b1, 12'h010, 4'b0101, 1'b1, 4'b0000, 1'b0};
      tbl[1] = '{1'b0, 12'h010, 4'b1111, 1'b0, 4'b0101, 1'b1};
      tbl[2] = '{1'b0, 12'h010, 4'b1010, 1'b0, 4'b0101, 1'b0};
      tbl[3] = '{1'b1, 12'h011, 4'b1000, 1'b1, 4'b0101, 1'b0};
      tbl[4] = '{1'b0, 12'h010, 4'b1000, 1'b0, 4'b1101, 1'b1};
      tbl[5] = '{1'b1, 12'h010, 4'b0001, 1'b0, 4'b1101, 1'b1};
      tbl[6] = '{1'b0, 12'h012, 4'b0011, 1'b0, 4'b1100, 1'b0};
      tbl[7] = '{1'b0, 12'h020, 4'b1111, 1'b0, 4'b0000, 1'b0};

      rst_n = 1'b0; clear_i = 1'b0;
      bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = '0; bus.be_i = '0; bus.wtag_i = 1'b0;
      foreach (refw[i]) refw[i] = '0;
      sweep_left = W; exp_rv = 1'b0; exp_rtag = '0; exp_any = 1'b0;
      repeat (2) @(negedge clk);
      #1 check_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // initial sweep with requests and stray clears that must be ignored
      for (int i = 0; i < W; i++) tick(1'b1, 1'b0, 12'h040, 4'hF, 1'b0, 1'($urandom_range(0, 1)));
      tick(1'b1, 1'b0, 12'h040, 4'hF, 1'b0, 1'b0);
      idle();

      // directed vectors, back-to-back
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) tick(1'b1, tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wtag, 1'b0);
         else idle();
         if (i > 0)
            chk("table_resp", 32'({last_rv, last_rtag, last_any}),
                32'({1'b1, tbl[i-1].exp_rtag, tbl[i-1].exp_any}));
      end

      // 8 distinct words, then 8 back-to-back reads
      for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 12'(12'h100 + i * 4), 4'(i), 1'b1, 1'b0);
      npulse = 0;
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) tick(1'b1, 1'b0, 12'(12'h100 + i * 4), 4'hF, 1'b0, 1'b0);
         else idle();
         if (i > 0) begin
            if (last_rv) npulse++;
            chk("b2b_tag", 32'(last_rtag), 32'(i - 1));
         end
      end
      chk("b2b_pulses", 32'(npulse), 32'(8));

      // grant right before clear keeps its response; clear+req is not granted
      tick(1'b1, 1'b0, 12'h010, 4'hF, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 12'h010, 4'hF, 1'b0, 1'b1);
      chk("pre_clear_resp", 32'({last_rv, last_rtag}), 32'({1'b1, 4'b1100}));
      for (int i = 0; i < W; i++) tick(1'($urandom_range(0, 1)), 1'b1, 12'h010, 4'hF, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 12'h010, 4'hF, 1'b0, 1'b0);
      idle();
      chk("post_clear_tag", 32'({last_rv, last_rtag}), 32'({1'b1, 4'b0000}));

      // reset 500 cycles into a sweep restarts it from word 0
      tick(1'b1, 1'b1, 12'h010, 4'hF, 1'b1, 1'b0);
      tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 500; i++) idle();
      async_reset_pulse();
      for (int i = 0; i < W; i++) idle();

      // reset while a response is pending drops it
      tick(1'b1, 1'b0, 12'h010, 4'hF, 1'b0, 1'b0);
      async_reset_pulse();
      for (int i = 0; i < W; i++) idle();

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++)
         tick(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 12'($urandom_range(0, 127)),
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 599) == 0));
      idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
